// File: rtl/branch_ctrl_if.sv
// Branch controller bus: fetch lookup, execute-stage branch, comparator link,
// redirect/flush outputs and statistics.
interface branch_ctrl_if;
    logic [31:0] fetch_pc;
    logic        pred_taken;
    logic        ex_valid;
    logic        ex_is_branch;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_pc;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic        stall;
    logic        brun;
    logic        brlt;
    logic        breq;
    logic        br_taken;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] branch_count;
    logic [31:0] mispredict_count;

    // Pipeline / comparator side
    modport master (
        output fetch_pc, ex_valid, ex_is_branch, ex_funct3, ex_pc, ex_target,
               ex_pred_taken, stall, brlt, breq,
        input  pred_taken, brun, br_taken, flush, redirect_valid, redirect_pc,
               branch_count, mispredict_count
    );

    // Branch controller side
    modport slave (
        input  fetch_pc, ex_valid, ex_is_branch, ex_funct3, ex_pc, ex_target,
               ex_pred_taken, stall, brlt, breq,
        output pred_taken, brun, br_taken, flush, redirect_valid, redirect_pc,
               branch_count, mispredict_count
    );
endinterface

// File: rtl/branch_ctrl.sv
// Branch resolution sequencer: comparator select, direction decode, 2-bit BHT
// prediction/update, mispredict redirect + multi-cycle flush, statistics.
module branch_ctrl #(
    parameter int unsigned IDX_BITS     = 6,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic         clk,
    input  logic         rst,
    branch_ctrl_if.slave bus
);
    localparam int unsigned ENTRIES = 1 << IDX_BITS;
    localparam int unsigned CTR_W   = 2;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned XLEN    = 32;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic                flush_q, flush_nxt;
    logic                rv_q, rv_nxt;
    logic [XLEN-1:0]     rpc_q, rpc_nxt;
    logic [XLEN-1:0]     branch_cnt, misp_cnt;
    logic [CTR_W-1:0]    bht [ENTRIES];

    logic [IDX_BITS-1:0] fetch_idx, ex_idx;
    logic                legal, dir, taken, resolve, mispredict;
    logic [CTR_W-1:0]    ctr_cur, ctr_nxt;
    logic                unused_fetch;

    assign fetch_idx    = bus.fetch_pc[IDX_BITS+1:2];
    assign ex_idx       = bus.ex_pc[IDX_BITS+1:2];
    assign unused_fetch = ^{bus.fetch_pc[XLEN-1:IDX_BITS+2], bus.fetch_pc[1:0]};

    // funct3 010/011 are not conditional branches
    assign legal = (bus.ex_funct3[2:1] != 2'b01);

    // Direction decode from comparator flags
    always_comb begin
        dir = 1'b0;
        case (bus.ex_funct3)
            3'b000:         dir = bus.breq;
            3'b001:         dir = !bus.breq;
            3'b100, 3'b110: dir = bus.brlt;
            3'b101, 3'b111: dir = !bus.brlt;
            default:        dir = 1'b0;
        endcase
    end

    assign taken      = bus.ex_valid & bus.ex_is_branch & legal & dir;
    assign resolve    = bus.ex_valid & bus.ex_is_branch & legal & !bus.stall
                        & (state == IDLE);
    assign mispredict = resolve & (taken != bus.ex_pred_taken);

    // Saturating counter update for the resolving branch
    always_comb begin
        ctr_cur = bht[ex_idx];
        ctr_nxt = ctr_cur;
        if (taken) begin
            if (ctr_cur != 2'b11) ctr_nxt = ctr_cur + 2'd1;
        end else begin
            if (ctr_cur != 2'b00) ctr_nxt = ctr_cur - 2'd1;
        end
    end

    // BHT storage; fetch read sees the pre-update value on a collision
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) bht[i] <= 2'b01;
        end else if (resolve) begin
            bht[ex_idx] <= ctr_nxt;
        end
    end

    // Next-state, flush timing and redirect generation
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        flush_nxt = flush_q;
        rv_nxt    = 1'b0;
        rpc_nxt   = rpc_q;
        case (state)
            IDLE: begin
                flush_nxt = 1'b0;
                if (mispredict) begin
                    state_nxt = FLUSH;
                    cnt_nxt   = CNT_W'(FLUSH_CYCLES - 1);
                    flush_nxt = 1'b1;
                    rv_nxt    = 1'b1;
                    rpc_nxt   = taken ? bus.ex_target : bus.ex_pc + 32'd4;
                end
            end
            FLUSH: begin
                if (cnt == '0) begin
                    state_nxt = IDLE;
                    flush_nxt = 1'b0;
                end else begin
                    cnt_nxt   = cnt - CNT_W'(1);
                    flush_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                flush_nxt = 1'b0;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            flush_q <= 1'b0;
            rv_q    <= 1'b0;
            rpc_q   <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            flush_q <= flush_nxt;
            rv_q    <= rv_nxt;
            rpc_q   <= rpc_nxt;
        end
    end

    // Saturating branch / mispredict statistics
    always_ff @(posedge clk) begin
        if (rst) begin
            branch_cnt <= '0;
            misp_cnt   <= '0;
        end else begin
            if (resolve && branch_cnt != '1) branch_cnt <= branch_cnt + 32'd1;
            if (mispredict && misp_cnt != '1) misp_cnt <= misp_cnt + 32'd1;
        end
    end

    assign bus.pred_taken       = bht[fetch_idx][1];
    assign bus.brun             = (bus.ex_funct3 == 3'b110) || (bus.ex_funct3 == 3'b111);
    assign bus.br_taken         = taken;
    assign bus.flush            = flush_q;
    assign bus.redirect_valid   = rv_q;
    assign bus.redirect_pc      = rpc_q;
    assign bus.branch_count     = branch_cnt;
    assign bus.mispredict_count = misp_cnt;
endmodule

// File: tb/tb_branch_ctrl.sv
// Directed bench for branch_ctrl (IDX_BITS=6, FLUSH_CYCLES=2).
module tb_branch_ctrl;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    branch_ctrl_if bus();

    branch_ctrl #(.IDX_BITS(6), .FLUSH_CYCLES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] tgt,
                         input logic pt, input logic lt, input logic eq);
        bus.ex_valid      = 1'b1;
        bus.ex_is_branch  = 1'b1;
        bus.ex_funct3     = f3;
        bus.ex_pc         = pc;
        bus.ex_target     = tgt;
        bus.ex_pred_taken = pt;
        bus.brlt          = lt;
        bus.breq          = eq;
    endtask

    task automatic check_pred(input string tag, input logic [31:0] pc, input logic exp);
        bus.fetch_pc = pc;
        #1;
        check(tag, 32'(bus.pred_taken), 32'(exp));
    endtask

    task automatic check_stats(input string tag, input logic [31:0] br, input logic [31:0] mp);
        check({tag, "_branch_count"}, bus.branch_count, br);
        check({tag, "_mispredict_count"}, bus.mispredict_count, mp);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.ex_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst               = 1'b1;
        bus.fetch_pc      = 32'h0;
        bus.ex_valid      = 1'b0;
        bus.ex_is_branch  = 1'b0;
        bus.ex_funct3     = 3'b000;
        bus.ex_pc         = 32'h0;
        bus.ex_target     = 32'h0;
        bus.ex_pred_taken = 1'b0;
        bus.stall         = 1'b0;
        bus.brlt          = 1'b0;
        bus.breq          = 1'b0;

        // Reset state
        do_reset();
        check("rst_flush", 32'(bus.flush), 32'd0);
        check("rst_redirect_valid", 32'(bus.redirect_valid), 32'd0);
        check("rst_redirect_pc", bus.redirect_pc, 32'h0);
        check_stats("rst", 32'd0, 32'd0);
        check_pred("rst_pred_100", 32'h100, 1'b0);

        // BEQ taken, predicted not taken: mispredict to target
        drive(3'b000, 32'h100, 32'h200, 1'b0, 1'b0, 1'b1);
        #1;
        check("beq_br_taken", 32'(bus.br_taken), 32'd1);
        check("beq_brun", 32'(bus.brun), 32'd0);
        tick();
        bus.ex_valid = 1'b0;
        check("beq_redirect_valid", 32'(bus.redirect_valid), 32'd1);
        check("beq_redirect_pc", bus.redirect_pc, 32'h200);
        check("beq_flush1", 32'(bus.flush), 32'd1);
        check_stats("beq", 32'd1, 32'd1);
        check_pred("beq_bht_10", 32'h100, 1'b1);
        tick();
        check("beq_redirect_pulse", 32'(bus.redirect_valid), 32'd0);
        check("beq_flush2", 32'(bus.flush), 32'd1);
        tick();
        check("beq_flush_end", 32'(bus.flush), 32'd0);

        // Comparator select and decode (stalled so nothing resolves)
        bus.stall = 1'b1;
        drive(3'b111, 32'h40, 32'h80, 1'b0, 1'b0, 1'b0);
        #1;
        check("bgeu_brun", 32'(bus.brun), 32'd1);
        check("bgeu_br_taken", 32'(bus.br_taken), 32'd1);
        bus.ex_funct3 = 3'b100;
        #1;
        check("blt_brun", 32'(bus.brun), 32'd0);
        check("blt_br_taken", 32'(bus.br_taken), 32'd0);
        bus.ex_valid = 1'b0;
        #1;
        check("novalid_br_taken", 32'(bus.br_taken), 32'd0);
        bus.stall = 1'b0;

        // Four correctly predicted taken branches saturate the counter
        do_reset();
        drive(3'b000, 32'h204, 32'h300, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("sat_no_redirect_%0d", i), 32'(bus.redirect_valid), 32'd0);
        end
        bus.ex_valid = 1'b0;
        check_stats("sat", 32'd4, 32'd0);
        check_pred("sat_pred", 32'h204, 1'b1);

        // Then not taken: mispredict to fall-through, counter 11 -> 10
        drive(3'b000, 32'h204, 32'h300, 1'b1, 1'b0, 1'b0);
        tick();
        check("nt_redirect_valid", 32'(bus.redirect_valid), 32'd1);
        check("nt_redirect_pc", bus.redirect_pc, 32'h208);
        check_stats("nt", 32'd5, 32'd1);

        // Branch presented during FLUSH is ignored
        drive(3'b001, 32'h204, 32'h600, 1'b0, 1'b0, 1'b0);
        tick();
        check("fl_redirect_valid", 32'(bus.redirect_valid), 32'd0);
        check("fl_flush", 32'(bus.flush), 32'd1);
        check_stats("fl1", 32'd5, 32'd1);
        tick();
        bus.ex_valid = 1'b0;
        check("fl_flush_end", 32'(bus.flush), 32'd0);
        check("fl_no_second_redirect", 32'(bus.redirect_valid), 32'd0);
        check_stats("fl2", 32'd5, 32'd1);
        check_pred("fl_bht_10", 32'h204, 1'b1);

        // Correct not-taken moves 10 -> 01, proving the flush-time branch left BHT alone
        drive(3'b000, 32'h204, 32'h300, 1'b0, 1'b0, 1'b0);
        tick();
        bus.ex_valid = 1'b0;
        check("dec_no_redirect", 32'(bus.redirect_valid), 32'd0);
        check_stats("dec", 32'd6, 32'd1);
        check_pred("dec_bht_01", 32'h204, 1'b0);

        // Stall blocks resolution; releasing it resolves normally
        bus.stall = 1'b1;
        drive(3'b000, 32'h400, 32'h500, 1'b0, 1'b0, 1'b1);
        tick();
        check("stall_no_redirect", 32'(bus.redirect_valid), 32'd0);
        check_stats("stall", 32'd6, 32'd1);
        check_pred("stall_bht", 32'h400, 1'b0);
        bus.stall = 1'b0;
        tick();
        bus.ex_valid = 1'b0;
        check("unstall_redirect_valid", 32'(bus.redirect_valid), 32'd1);
        check("unstall_redirect_pc", bus.redirect_pc, 32'h500);
        check_stats("unstall", 32'd7, 32'd2);
        check_pred("unstall_bht", 32'h400, 1'b1);
        tick();
        check("mid_flush", 32'(bus.flush), 32'd1);

        // Reset in 2nd flush cycle, with a resolvable branch coincident with rst
        rst = 1'b1;
        drive(3'b000, 32'h100, 32'h200, 1'b0, 1'b0, 1'b1);
        tick();
        check("rstf_flush", 32'(bus.flush), 32'd0);
        check("rstf_redirect_valid", 32'(bus.redirect_valid), 32'd0);
        check("rstf_redirect_pc", bus.redirect_pc, 32'h0);
        check_stats("rstf", 32'd0, 32'd0);
        tick();
        check("rstf2_redirect_valid", 32'(bus.redirect_valid), 32'd0);
        check_stats("rstf2", 32'd0, 32'd0);
        check_pred("rstf_pred_100", 32'h100, 1'b0);
        check_pred("rstf_pred_400", 32'h400, 1'b0);
        check_pred("rstf_pred_204", 32'h204, 1'b0);
        rst = 1'b0;
        bus.ex_valid = 1'b0;

        // Illegal funct3 010/011: no decode, no count, no mispredict
        drive(3'b010, 32'h100, 32'h200, 1'b1, 1'b1, 1'b1);
        #1;
        check("f010_br_taken", 32'(bus.br_taken), 32'd0);
        tick();
        check("f010_no_redirect", 32'(bus.redirect_valid), 32'd0);
        check_stats("f010", 32'd0, 32'd0);
        bus.ex_funct3 = 3'b011;
        tick();
        bus.ex_valid = 1'b0;
        check("f011_no_redirect", 32'(bus.redirect_valid), 32'd0);
        check_stats("f011", 32'd0, 32'd0);
        check_pred("f011_bht", 32'h100, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
